// File: rtl/ram_port_arbiter_pkg.sv
// ram_ctrl_defs: shared state encodings and requester ids for the RAM port controllers
package ram_ctrl_defs;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: two requester ports, their response paths and the RAM port
interface ram_port_arbiter_if #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
);
    logic              req0_valid, req1_valid;
    logic              req0_we, req1_we;
    logic [AWIDTH-1:0] req0_addr, req1_addr;
    logic [DWIDTH-1:0] req0_wdata, req1_wdata;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic [DWIDTH-1:0] rsp0_rdata, rsp1_rdata;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_din;
    logic              ram_we;
    logic [DWIDTH-1:0] ram_dout;
    logic              init_done;

    modport slave (
        input  req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr,
               req0_wdata, req1_wdata, ram_dout,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
               ram_addr, ram_din, ram_we, init_done
    );

    modport master (
        output req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr,
               req0_wdata, req1_wdata, ram_dout,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
               ram_addr, ram_din, ram_we, init_done
    );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with pointer update on handshake
module rr_arb2
    import ram_ctrl_defs::*;
(
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    input  logic       handshake_i,
    output logic [1:0] grant_o,
    output logic       ptr_o
);

    // Contention resolves to the pointed-at requester; after any grant the pointer moves to the other one
    always_comb begin
        grant_o = &valid_i ? (ptr_i == REQ1 ? 2'b10 : 2'b01) : valid_i;
        ptr_o   = handshake_i ? (grant_o[REQ1] ? REQ0 : REQ1) : ptr_i;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of a sync-read RAM port between two requesters, optional clear after reset
module ram_port_arbiter
    import ram_ctrl_defs::*;
#(
    parameter int AWIDTH         = 3,
    parameter int DWIDTH         = 32,
    parameter bit CLEAR_ON_RESET = 1'b0
) (
    input logic clk_i,
    input logic rst_i,
    ram_port_arbiter_if.slave bus
);

    localparam logic [AWIDTH:0] LAST = (AWIDTH+1)'((1 << AWIDTH) - 1);

    state_e          state_q;
    logic [AWIDTH:0] clr_cnt_q;
    logic            rr_ptr_q, rr_ptr_d;
    logic            pend_valid_q, pend_id_q;
    logic            init_done_q;
    logic            serve, sel_we, rd_hs;
    logic [1:0]      valid, grant;

    assign serve  = state_q == ST_SERVE;
    assign valid  = {bus.req1_valid, bus.req0_valid} & {2{serve}};
    assign sel_we = grant[REQ1] ? bus.req1_we : bus.req0_we;
    assign rd_hs  = |grant & ~sel_we;

    rr_arb2 u_arb (
        .valid_i    (valid),
        .ptr_i      (rr_ptr_q),
        .handshake_i(|valid),
        .grant_o    (grant),
        .ptr_o      (rr_ptr_d)
    );

    assign bus.req0_ready = grant[REQ0];
    assign bus.req1_ready = grant[REQ1];
    assign bus.init_done  = init_done_q;

    // RAM port: clear sweep in INIT, otherwise the granted requester or idle zeros
    always_comb begin
        bus.ram_we   = serve ? |grant & sel_we : 1'b1;
        bus.ram_addr = !serve ? clr_cnt_q[AWIDTH-1:0] :
                       grant[REQ1] ? bus.req1_addr : grant[REQ0] ? bus.req0_addr : '0;
        bus.ram_din  = !serve ? '0 :
                       grant[REQ1] ? bus.req1_wdata : grant[REQ0] ? bus.req0_wdata : '0;
    end

    // Read data is routed straight from the RAM to whichever requester owns the pending read
    always_comb begin
        bus.rsp0_valid = pend_valid_q & (pend_id_q == REQ0);
        bus.rsp1_valid = pend_valid_q & (pend_id_q == REQ1);
        bus.rsp0_rdata = bus.rsp0_valid ? bus.ram_dout : '0;
        bus.rsp1_rdata = bus.rsp1_valid ? bus.ram_dout : '0;
    end

    // Controller FSM: clear sweep, then serve with round-robin pointer and pending-read tracking
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= CLEAR_ON_RESET ? ST_INIT : ST_SERVE;
            clr_cnt_q    <= '0;
            rr_ptr_q     <= REQ0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= REQ0;
            init_done_q  <= !CLEAR_ON_RESET;
        end else begin
            case (state_q)
                ST_INIT: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST) begin
                        state_q     <= ST_SERVE;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    rr_ptr_q     <= rr_ptr_d;
                    pend_valid_q <= rd_hs;
                    pend_id_q    <= grant[REQ1];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed checks of clear sweep, routing, round-robin order and mid-op reset
module tb_ram_port_arbiter;

    localparam int AW = 3;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    ram_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    logic [DW-1:0] mem [2**AW];

    // Synchronous-read RAM model: address sampled on the edge, data valid the next cycle
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req0_valid = v;
        bus.req0_we    = we;
        bus.req0_addr  = a;
        bus.req0_wdata = d;
    endtask

    task automatic set1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req1_valid = v;
        bus.req1_we    = we;
        bus.req1_addr  = a;
        bus.req1_wdata = d;
    endtask

    task automatic check_sweep();
        for (int i = 0; i < 2**AW; i++) begin
            check("init_we", 64'(bus.ram_we), 64'(1));
            check("init_addr", 64'(bus.ram_addr), 64'(i));
            check("init_din", 64'(bus.ram_din), 64'(0));
            check("init_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(0));
            check("init_done_low", 64'(bus.init_done), 64'(0));
            step();
        end
        check("init_done_high", 64'(bus.init_done), 64'(1));
    endtask

    // Contention table: {v1,v0}, expected {ready1,ready0}, expected {rsp1,rsp0} valid
    logic [1:0] tv [9] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    logic [1:0] tr [9] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    logic [1:0] ts [9] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};

    initial begin
        set0(1'b1, 1'b0, '0, '0);
        set1(1'b1, 1'b0, '0, '0);
        #1;
        check("rst_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(0));
        check("rst_rspv", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(0));
        check("rst_rdata0", 64'(bus.rsp0_rdata), 64'(0));
        check("rst_rdata1", 64'(bus.rsp1_rdata), 64'(0));
        check("rst_we", 64'(bus.ram_we), 64'(1));
        check("rst_init_done", 64'(bus.init_done), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        check_sweep();
        set1(1'b0, 1'b0, '0, '0);

        set0(1'b1, 1'b0, 3'd5, '0);
        #1;
        check("rd5_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(1));
        check("rd5_we", 64'(bus.ram_we), 64'(0));
        check("rd5_addr", 64'(bus.ram_addr), 64'(5));
        step();
        set0(1'b0, 1'b0, '0, '0);
        #1;
        check("rd5_rspv", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(1));
        check("rd5_data", 64'(bus.rsp0_rdata), 64'(0));

        set0(1'b1, 1'b1, 3'd2, 32'hDEADBEEF);
        #1;
        check("wr2_we", 64'(bus.ram_we), 64'(1));
        check("wr2_addr", 64'(bus.ram_addr), 64'(2));
        check("wr2_din", 64'(bus.ram_din), 64'(32'hDEADBEEF));
        step();
        set0(1'b1, 1'b0, 3'd2, '0);
        #1;
        check("wr2_no_rsp", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(0));
        step();
        set0(1'b0, 1'b0, '0, '0);
        #1;
        check("rd2_rspv", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(1));
        check("rd2_data", 64'(bus.rsp0_rdata), 64'(32'hDEADBEEF));
        check("rd2_rdata1", 64'(bus.rsp1_rdata), 64'(0));

        set0(1'b1, 1'b1, 3'd1, 32'h11111111);
        step();
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b1, 1'b1, 3'd6, 32'h66666666);
        #1;
        check("wr6_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(2));
        step();

        for (int c = 0; c < 9; c++) begin
            set0(tv[c][0], 1'b0, 3'd1, '0);
            set1(tv[c][1], 1'b0, 3'd6, '0);
            #1;
            check($sformatf("rr_ready_c%0d", c), 64'({bus.req1_ready, bus.req0_ready}), 64'(tr[c]));
            check($sformatf("rr_rspv_c%0d", c), 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(ts[c]));
            check($sformatf("rr_rdata0_c%0d", c), 64'(bus.rsp0_rdata), 64'(ts[c][0] ? 32'h11111111 : 32'h0));
            check($sformatf("rr_rdata1_c%0d", c), 64'(bus.rsp1_rdata), 64'(ts[c][1] ? 32'h66666666 : 32'h0));
            step();
        end

        set1(1'b1, 1'b1, 3'd7, 32'h77770000);
        step();
        set1(1'b0, 1'b0, '0, '0);
        set0(1'b1, 1'b0, 3'd7, '0);
        step();
        set0(1'b0, 1'b0, '0, '0);
        #1;
        check("wr7rd7_rspv", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(1));
        check("wr7rd7_data", 64'(bus.rsp0_rdata), 64'(32'h77770000));

        set0(1'b1, 1'b0, 3'd7, '0);
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_rspv", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(0));
        check("mid_rst_rdata0", 64'(bus.rsp0_rdata), 64'(0));
        check("mid_rst_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(0));
        check("mid_rst_we", 64'(bus.ram_we), 64'(1));
        check("mid_rst_addr", 64'(bus.ram_addr), 64'(0));
        check("mid_rst_init_done", 64'(bus.init_done), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        check_sweep();

        set0(1'b1, 1'b0, 3'd1, '0);
        set1(1'b1, 1'b0, 3'd6, '0);
        #1;
        check("ptr_reset_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(1));
        step();
        set0(1'b1, 1'b0, 3'd2, '0);
        set1(1'b0, 1'b0, '0, '0);
        #1;
        check("clr1_rspv", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(1));
        check("clr1_data", 64'(bus.rsp0_rdata), 64'(0));
        step();
        set0(1'b0, 1'b0, '0, '0);
        #1;
        check("clr2_rspv", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(1));
        check("clr2_data", 64'(bus.rsp0_rdata), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
